axi_rd_sram: RTL and testbench
==============================

# axi_rd_sram

Read-only AXI4 responder that serves the instruction cache's line-fill bursts from an internal word-addressed memory. It sits at the far end of the icache refill channel, standing in for instruction memory in simulation and FPGA builds. It accepts one read burst at a time (FIXED/INCR/WRAP, up to 16 beats) and returns 64-bit beats with ID echo, response code and last flag. A synchronous backdoor write port loads the image.

## Interface
- `DEPTH`, 4096: memory size in 64-bit words; power of two.
- `LATENCY`, 0: extra idle cycles between AR acceptance and the first R beat; 0..15.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `arvalid`  in  1  read address valid.
- `arready`  out  1  read address ready.
- `araddr`  in  64  byte address of the first beat.
- `arid`  in  4  transaction ID.
- `arlen`  in  8  beats minus one; 0..15 supported.
- `arsize`  in  3  bytes per beat = 1<<arsize; 0..3.
- `arburst`  in  2  0 FIXED, 1 INCR, 2 WRAP.
- `rvalid`  out  1  read data valid.
- `rready`  in  1  read data ready.
- `rdata`  out  64  aligned 64-bit word containing the beat address.
- `rresp`  out  2  00 OKAY, 10 SLVERR.
- `rlast`  out  1  final beat of burst.
- `rid`  out  4  echo of `arid`.
- `ld_we`  in  1  backdoor write enable.
- `ld_addr`  in  log2(DEPTH)  backdoor word index.
- `ld_data`  in  64  backdoor write data.

## Operation
- States: IDLE, WAIT, BURST.
- IDLE: `arready`=1. On `arvalid&arready`, capture addr/id/len/size/burst and zero beat counter; go to WAIT if LATENCY>0 (load countdown = LATENCY), else BURST.
- WAIT: `arready`=0, `rvalid`=0; countdown decrements each cycle; go to BURST when it reaches 1.
- BURST: `rvalid`=1 presenting current beat. On `rvalid&rready`: if beat counter == captured len, go to IDLE; else increment counter and advance address.
- Address advance: FIXED keeps address. INCR adds 1<<size. WRAP adds 1<<size and, within the block of (len+1)<<size bytes aligned to that size, wraps to block base.
- `rdata` = mem[addr[3+log2(DEPTH)-1:3]]; master extracts byte lanes from addr[2:0].
- `rresp`=SLVERR (and `rdata`=0) for a beat when addr >= DEPTH*8; a bad parameter set (arlen>15, arsize>3, arburst=3, WRAP with len not in {1,3,7,15}) makes every beat of that burst SLVERR, beat count still len+1 capped at 16 beats (len taken as arlen[3:0]).
- `rid` constant for the whole burst; `rlast`=1 only when counter == len.
- `ld_we` writes mem[ld_addr] at the clock edge; a same-cycle read of that word returns old data. Loading during a burst is permitted; beats presented after the write see new data.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: state IDLE, `arready`=0 while `rst` high, 1 from the first edge after release; `rvalid`=0, `rlast`=0, `rresp`=00, `rid`=0, `rdata`=0.
- AR accepted at edge T: `arready`=0 from T; first `rvalid` visible after edge T+LATENCY+... i.e. cycle T+1+LATENCY.
- Beats are back-to-back (one per cycle) while `rready`=1; with `rready`=0, `rvalid`, `rdata`, `rresp`, `rlast`, `rid` hold stable.
- Last beat accepted at edge L: `rvalid`=0 and `arready`=1 from L; next AR may be accepted at L+1; no overlap of bursts.
- `rst` asserted mid-burst: immediately IDLE, `rvalid`=0; burst discarded; no beat emitted after release until a new AR.

## Test plan
- INCR: load mem[i]=0x1000+i, AR addr 0x40 len 3 size 3 id 5, rready=1 -> 4 consecutive beats 0x1008..0x100B, rid 5, OKAY, rlast on 4th, `arready` back next edge.
- WRAP: AR addr 0x50 len 3 size 3 -> beats words 0x0A,0x0B,0x08,0x09 (data 0x100A,0x100B,0x1008,0x1009).
- Backpressure: INCR len 7 with rready toggling 1,0,0,1,... -> outputs stable during stalls, exactly 8 handshakes, rlast only on 8th.
- Error: AR addr DEPTH*8-8 len 1 INCR -> beat 0 OKAY with mem[DEPTH-1], beat 1 SLVERR data 0; AR arburst=3 len 0 -> single SLVERR beat with rlast.
- LATENCY=3 build: AR at T -> `rvalid` first high at T+4; FIXED len 2 -> three identical beats.
- Reset mid-burst: assert `rst` after beat 1 of len 7 -> `rvalid`=0 immediately, `arready`=0 in reset, 1 one edge after release, new AR served correctly.

Source files
------------

// File: rtl/axi_rd_sram.sv
// axi_rd_sram: read-only AXI4 burst responder over a backdoor-loaded 64-bit word memory
module axi_rd_sram #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [63:0]              araddr,
  input  logic [3:0]               arid,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [63:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic [3:0]               rid,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [63:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state, state_n;
  logic [63:0] mem [DEPTH];
  logic [63:0] addr, addr_n, step, mask;
  logic [3:0] id, len, cnt, wcnt;
  logic [1:0] size, burst;
  logic bad, up, ar_hs, r_hs, last, err;
  // backdoor image load; contents survive reset
  always_ff @(posedge clk)
    if (ld_we) mem[ld_addr] <= ld_data;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // handshakes, beat status, next-state and response outputs
  always_comb begin
    arready = up && state == IDLE;
    rvalid  = state == BURST;
    ar_hs   = arvalid && arready;
    r_hs    = rvalid && rready;
    last    = cnt == len;
    err     = bad || addr[63:AW+3] != '0;
    rlast   = rvalid && last;
    rresp   = rvalid && err ? 2'b10 : 2'b00;
    rdata   = rvalid && !err ? mem[addr[AW+2:3]] : 64'd0;
    rid     = id;
    step    = 64'd1 << size;
    mask    = (({60'd0, len} + 64'd1) << size) - 64'd1;
    addr_n  = burst == 2'd0 ? addr :
              burst == 2'd2 ? (addr & ~mask) | ((addr + step) & mask) : addr + step;
    state_n = state;
    case (state)
      IDLE:    state_n = ar_hs ? (LATENCY > 0 ? WAIT : BURST) : IDLE;
      WAIT:    state_n = wcnt == 4'd1 ? BURST : WAIT;
      BURST:   state_n = r_hs && last ? IDLE : BURST;
      default: state_n = IDLE;
    endcase
  end
  // burst context capture, latency countdown and beat address stepping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      up    <= 1'b0;
      addr  <= '0;
      id    <= '0;
      len   <= '0;
      cnt   <= '0;
      wcnt  <= '0;
      size  <= '0;
      burst <= '0;
      bad   <= 1'b0;
    end else begin
      up <= 1'b1;
      if (ar_hs) begin
        addr  <= araddr;
        id    <= arid;
        len   <= arlen[3:0];
        size  <= arsize[1:0];
        burst <= arburst;
        cnt   <= '0;
        wcnt  <= 4'(LATENCY);
        bad   <= arlen[7:4] != '0 || arsize[2] || arburst == 2'd3 ||
                 (arburst == 2'd2 && !(arlen[3:0] inside {4'd1, 4'd3, 4'd7, 4'd15}));
      end else if (state == WAIT) wcnt <= wcnt - 4'd1;
      else if (r_hs && !last) begin
        cnt  <= cnt + 4'd1;
        addr <= addr_n;
      end
    end
endmodule

// File: tb/tb_axi_rd_sram.sv
// tb_axi_rd_sram: directed checks of bursts, wrap, backpressure, errors, latency and reset
module tb_axi_rd_sram;
  localparam int DEPTH = 256;
  logic clk = 0, rst = 1;
  logic av0 = 0, av3 = 0, rready = 0;
  logic [63:0] araddr = 0;
  logic [3:0] arid = 0;
  logic [7:0] arlen = 0;
  logic [2:0] arsize = 0;
  logic [1:0] arburst = 0;
  logic ld_we = 0;
  logic [7:0] ld_addr = 0;
  logic [63:0] ld_data = 0;
  logic arready, rvalid, rlast, ar3_rdy, rv3, rl3;
  logic [63:0] rdata, rd3;
  logic [1:0] rresp, rr3;
  logic [3:0] rid, rid3;
  int nchk = 0, nerr = 0;
  axi_rd_sram #(.DEPTH(DEPTH), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .arvalid(av0), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data));
  axi_rd_sram #(.DEPTH(DEPTH), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .arvalid(av3), .arready(ar3_rdy), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rv3), .rready(rready),
    .rdata(rd3), .rresp(rr3), .rlast(rl3), .rid(rid3), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ar0(input logic [63:0] a, input logic [3:0] i, input logic [7:0] l,
                     input logic [2:0] s, input logic [1:0] b);
    araddr = a; arid = i; arlen = l; arsize = s; arburst = b; av0 = 1;
    chk("ar_ready", arready, 1);
    tick;
    av0 = 0;
  endtask
  task automatic beat0(input string tag, input logic [63:0] d, input logic [1:0] r,
                       input logic l, input logic [3:0] i);
    rready = 1;
    chk({tag, "_valid"}, rvalid, 1);
    chk({tag, "_data"}, rdata, d);
    chk({tag, "_resp"}, rresp, r);
    chk({tag, "_last"}, rlast, l);
    chk({tag, "_id"}, rid, i);
    tick;
  endtask
  initial begin
    int beat, hs;
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rid", rid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ld_we = 1; ld_addr = 8'(i); ld_data = 64'h1000 + 64'(i);
      tick;
    end
    ld_we = 0;
    chk("rst_hold_arready", arready, 0);
    rst = 0;
    chk("rel_arready_before_edge", arready, 0);
    tick;
    chk("rel_arready", arready, 1);
    // INCR len 3 from word 8
    ar0(64'h40, 4'd5, 8'd3, 3'd3, 2'd1);
    chk("incr_arready_busy", arready, 0);
    beat0("incr0", 64'h1008, 2'b00, 0, 4'd5);
    beat0("incr1", 64'h1009, 2'b00, 0, 4'd5);
    beat0("incr2", 64'h100A, 2'b00, 0, 4'd5);
    beat0("incr3", 64'h100B, 2'b00, 1, 4'd5);
    chk("incr_done_rvalid", rvalid, 0);
    chk("incr_done_arready", arready, 1);
    // WRAP len 3 starting mid-block
    ar0(64'h50, 4'd2, 8'd3, 3'd3, 2'd2);
    beat0("wrap0", 64'h100A, 2'b00, 0, 4'd2);
    beat0("wrap1", 64'h100B, 2'b00, 0, 4'd2);
    beat0("wrap2", 64'h1008, 2'b00, 0, 4'd2);
    beat0("wrap3", 64'h1009, 2'b00, 1, 4'd2);
    // backpressure: rready 1,0,0 repeating
    ar0(64'h0, 4'd7, 8'd7, 3'd3, 2'd1);
    beat = 0; hs = 0;
    for (int k = 0; k < 40 && beat < 8; k++) begin
      rready = (k % 3) == 0;
      chk("bp_valid", rvalid, 1);
      chk("bp_data", rdata, 64'h1000 + 64'(beat));
      chk("bp_last", rlast, beat == 7);
      chk("bp_id", rid, 4'd7);
      tick;
      if (rready) begin beat++; hs++; end
    end
    chk("bp_handshakes", 64'(hs), 8);
    chk("bp_done_rvalid", rvalid, 0);
    rready = 1;
    // top-of-memory crossing and reserved burst type
    ar0(64'(DEPTH * 8 - 8), 4'd3, 8'd1, 3'd3, 2'd1);
    beat0("edge0", 64'h10FF, 2'b00, 0, 4'd3);
    beat0("edge1", 64'h0, 2'b10, 1, 4'd3);
    ar0(64'h8, 4'd4, 8'd0, 3'd3, 2'd3);
    beat0("badburst", 64'h0, 2'b10, 1, 4'd4);
    chk("badburst_done", rvalid, 0);
    // LATENCY=3 instance with FIXED len 2
    araddr = 64'h18; arid = 4'd6; arlen = 8'd2; arsize = 3'd3; arburst = 2'd0; av3 = 1;
    chk("lat_arready", ar3_rdy, 1);
    tick;
    av3 = 0;
    chk("lat_w1", rv3, 0);
    chk("lat_busy_arready", ar3_rdy, 0);
    tick;
    chk("lat_w2", rv3, 0);
    tick;
    chk("lat_w3", rv3, 0);
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("lat_valid", rv3, 1);
      chk("lat_data", rd3, 64'h1003);
      chk("lat_resp", rr3, 0);
      chk("lat_last", rl3, k == 2);
      chk("lat_id", rid3, 4'd6);
      tick;
    end
    chk("lat_done", rv3, 0);
    // reset in the middle of an INCR len 7
    ar0(64'h0, 4'd1, 8'd7, 3'd3, 2'd1);
    beat0("mid0", 64'h1000, 2'b00, 0, 4'd1);
    beat0("mid1", 64'h1001, 2'b00, 0, 4'd1);
    rst = 1;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_arready", arready, 0);
    tick;
    tick;
    chk("mid_hold_arready", arready, 0);
    rst = 0;
    chk("mid_rel_rvalid", rvalid, 0);
    tick;
    chk("mid_rel_arready", arready, 1);
    chk("mid_rel_rvalid2", rvalid, 0);
    ar0(64'h20, 4'd9, 8'd0, 3'd3, 2'd1);
    beat0("post", 64'h1004, 2'b00, 1, 4'd9);
    chk("post_done", rvalid, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
